// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs it into big-endian 32-bit words,
// writes them to instruction memory from address 0 and releases the CPU once the XOR checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;

    logic [15:0]           r_len;
    logic [23:0]           r_shift;
    logic [1:0]            r_bcnt;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [7:0]            r_xor;

    logic                  r_in_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wd;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;

    logic                  w_acc;
    logic                  w_start_ok;
    logic [16:0]           w_len_full;
    logic [16:0]           w_widx_p1;
    logic                  w_last_word;
    logic                  w_next_rdy;

    assign w_acc       = in_valid && r_in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_len_full  = {1'b0, r_len[15:8], in_data};
    assign w_widx_p1   = 17'(r_widx) + 17'd1;
    // Current word is the final one of the image when index+1 reaches the word count.
    assign w_last_word = (w_widx_p1 == {1'b0, r_len});
    assign w_next_rdy  = (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                         (w_next == S_PAYLOAD) || (w_next == S_CHECK);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_acc) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_acc) begin
                    if (w_len_full > CAPACITY) w_next = S_ERR;
                    else if (w_len_full == 17'd0) w_next = S_CHECK;
                    else w_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_acc && r_bcnt == 2'd3 && w_last_word) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_acc) w_next = (in_data == r_xor) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_len       <= '0;
            r_shift     <= '0;
            r_bcnt      <= '0;
            r_widx      <= '0;
            r_xor       <= '0;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_in_ready  <= w_next_rdy;
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERR);
            r_cpu_reset <= (w_next != S_DONE);

            if (w_start_ok) begin
                r_len   <= '0;
                r_shift <= '0;
                r_bcnt  <= '0;
                r_widx  <= '0;
                r_xor   <= '0;
            end

            case (r_state)
                S_LEN_HI: begin
                    if (w_acc) r_len[15:8] <= in_data;
                end
                S_LEN_LO: begin
                    if (w_acc) r_len[7:0] <= in_data;
                end
                S_PAYLOAD: begin
                    if (w_acc) begin
                        r_xor  <= r_xor ^ in_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_we   <= 1'b1;
                            r_wd   <= {r_shift, in_data};
                            r_addr <= r_widx;
                            // Hold the index on the final word so it never wraps at full capacity.
                            if (!w_last_word) r_widx <= r_widx + 1'b1;
                        end else begin
                            r_shift <= {r_shift[15:0], in_data};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign imem_we   = r_we;
    assign imem_addr = r_addr;
    assign imem_wd   = r_wd;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a queue-based image model.
module tb_imem_loader;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    bit          armed = 1'b0;

    logic [7:0]  pay [$];
    logic [31:0] exp_wd [$];
    int          exp_ad [$];
    logic [31:0] mword [0:CAP-1];
    logic [7:0]  mxor;
    logic [31:0] dmem [0:CAP-1];
    int          wcnt [0:CAP-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every write is matched against the model's ordered list of (address, word).
    always @(negedge CLK) begin
        if (armed) begin
            chk("we_known", {31'd0, imem_we === 1'bx}, 32'd0);
            if (imem_we === 1'b1) begin
                if (exp_wd.size() == 0) begin
                    chk("spurious_we", {24'd0, imem_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("wr_addr", {24'd0, imem_addr}, exp_ad.pop_front());
                    chk("wr_data", imem_wd, exp_wd.pop_front());
                end
                dmem[imem_addr] = imem_wd;
                wcnt[imem_addr] = wcnt[imem_addr] + 1;
            end
            chk("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
            chk("done_error_excl", {31'd0, done & error}, 32'd0);
        end
    end

    task automatic build_model(input int n);
        mxor = 8'h00;
        foreach (pay[i]) mxor = mxor ^ pay[i];
        if (n <= CAP) begin
            for (int i = 0; i < n; i++) begin
                mword[i] = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
                exp_ad.push_back(i);
                exp_wd.push_back(mword[i]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int t;
        int gap;
        gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge CLK);
            if (in_ready === 1'b1) break;
            t++;
            if (t > 100) begin
                n_err++;
                $display("FAIL ready_timeout: in_ready stuck at %b, required 1", in_ready);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $fatal(1, "in_ready timeout");
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom_range(0, 255);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        chk("start_ready", {31'd0, in_ready}, 32'd1);
        chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_error", {31'd0, error}, 32'd0);
    endtask

    // Streams LEN, the payload in `pay` and the checksum, then checks the final status.
    task automatic load(input int n, input bit corrupt, input int maxgap);
        logic [15:0] len;
        len = 16'(n);
        build_model(n);
        do_start();
        send_byte(len[15:8], maxgap);
        send_byte(len[7:0], maxgap);
        if (n > CAP) begin
            chk("len_err", {31'd0, error}, 32'd1);
            chk("len_err_ready", {31'd0, in_ready}, 32'd0);
            chk("len_err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        end else begin
            foreach (pay[i]) send_byte(pay[i], maxgap);
            send_byte(mxor ^ {7'd0, corrupt}, maxgap);
            chk("end_done", {31'd0, done}, {31'd0, ~corrupt});
            chk("end_error", {31'd0, error}, {31'd0, corrupt});
            chk("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, corrupt});
            chk("end_ready", {31'd0, in_ready}, 32'd0);
            chk("writes_pending", exp_wd.size(), 32'd0);
            if (n > 0) chk("addr_hold", {24'd0, imem_addr}, n - 1);
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic rand_payload(input int n);
        pay.delete();
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_wd"}, imem_wd, 32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < CAP; i++) begin
            dmem[i] = 32'h0;
            wcnt[i] = 0;
        end

        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        armed = 1'b1;
        reset = 1'b1;
        check_reset_values("rst");

        pay = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
        load(2, 1'b0, 0);
        chk("model_xor", {24'd0, mxor}, 32'h55);
        chk("img_w0", dmem[0], 32'h2008_0005);
        chk("img_w1", dmem[1], 32'h0109_5020);
        chk("img_cnt0", wcnt[0], 32'd1);
        chk("img_cnt1", wcnt[1], 32'd1);

        load(2, 1'b1, 0);
        chk("bad_w0", dmem[0], 32'h2008_0005);
        chk("bad_w1", dmem[1], 32'h0109_5020);
        chk("bad_cnt1", wcnt[1], 32'd2);

        pay.delete();
        load(257, 1'b0, 0);
        pay.delete();
        load(0, 1'b0, 0);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 6);
            rand_payload(n);
            load(n, 1'($urandom_range(0, 1)), 2);
        end

        for (int i = 0; i < CAP; i++) wcnt[i] = 0;
        rand_payload(CAP);
        load(CAP, 1'b0, 3);
        for (int i = 0; i < CAP; i++) begin
            chk("full_word", dmem[i], mword[i]);
            chk("full_cnt", wcnt[i], 32'd1);
        end

        pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
        check_reset_values("midrst");
        repeat (4) @(posedge CLK);
        #1;
        wcnt[0] = 0;
        load(1, 1'b0, 1);
        chk("midrst_w0", dmem[0], 32'hDEAD_BEEF);
        chk("midrst_cnt0", wcnt[0], 32'd1);

        repeat (2) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
